team_11_keypad_scan: RTL

Column-scanning receiver for the team 11 4x4 keypad on GPIO. It drives one column high at a time on mprj_io, samples the four row inputs (mprj_io[37:34]), debounces a press, and emits one key event per physical press as a 4-bit key code plus its ASCII character. The message/display logic that builds msg_1 consumes those events.

---
 rtl/team_11_keypad_pkg.sv | 29 ++
 rtl/team_11_sync2.sv | 27 ++
 rtl/team_11_keypad_scan.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/team_11_keypad_pkg.sv
// Shared types, key map and helpers for the team 11 keypad scanner.
package team_11_keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2
    } state_e;

    // ASCII of each key, indexed by key_code = {row_idx, col_idx} (row-major).
    localparam logic [7:0] KEY_ASCII [0:15] = '{
        8'h31, 8'h32, 8'h33, 8'h41,   // 1 2 3 A
        8'h34, 8'h35, 8'h36, 8'h42,   // 4 5 6 B
        8'h37, 8'h38, 8'h39, 8'h43,   // 7 8 9 C
        8'h2A, 8'h30, 8'h23, 8'h44    // * 0 # D
    };

    // Lowest set row wins; an all-zero pattern encodes as row 0.
    function automatic logic [1:0] prio_enc(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        if (v[0])      idx = 2'd0;
        else if (v[1]) idx = 2'd1;
        else if (v[2]) idx = 2'd2;
        else if (v[3]) idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/team_11_sync2.sv
// Parameterized-width two-flop synchronizer for asynchronous inputs.
module team_11_sync2 #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Two back-to-back flops; the first may go metastable, the second settles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/team_11_keypad_scan.sv
// Column-scanning 4x4 keypad receiver with press/release debounce.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SCAN     | drive one column per dwell period, sample rows at its end
// PRESS_DB | column frozen, wait for the latched row pattern to be stable
// HELD     | key accepted, column frozen until the release is stable
module team_11_keypad_scan
    import team_11_keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 1000,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic       key_valid_o,
    output logic [3:0] key_code_o,
    output logic [7:0] key_ascii_o,
    output logic       key_held_o
);

    localparam int CMAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [3:0]    rs;

    state_e        state_q, state_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [3:0]    col_q, col_d;
    logic [CW-1:0] dwell_q, dwell_d;
    logic [CW-1:0] db_q, db_d;
    logic [3:0]    pat_q, pat_d;
    logic [3:0]    code_q, code_d;
    logic [7:0]    ascii_q, ascii_d;
    logic          valid_q, valid_d;
    logic          held_q, held_d;

    logic          dwell_end;
    logic          db_end;
    logic          rs_any;
    logic          rs_match;
    logic [3:0]    code_new;

    team_11_sync2 #(.W(4)) u_row_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (row_i),
        .q_o   (rs)
    );

    assign dwell_end = (dwell_q == SCAN_LAST);
    assign db_end    = (db_q == DB_LAST);
    assign rs_any    = (rs != 4'b0000);
    assign rs_match  = (rs == pat_q);
    assign code_new  = {prio_enc(pat_q), col_idx_q};

    // State, counters and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= SCAN;
            col_idx_q <= 2'd0;
            col_q     <= 4'b0001;
            dwell_q   <= '0;
            db_q      <= '0;
            pat_q     <= 4'b0000;
            code_q    <= 4'h0;
            ascii_q   <= 8'h00;
            valid_q   <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            col_q     <= col_d;
            dwell_q   <= dwell_d;
            db_q      <= db_d;
            pat_q     <= pat_d;
            code_q    <= code_d;
            ascii_q   <= ascii_d;
            valid_q   <= valid_d;
            held_q    <= held_d;
        end
    end

    // Next-state selection; disable always falls back to scanning.
    always_comb begin
        state_d = state_q;
        if (!en_i) begin
            state_d = SCAN;
        end else begin
            case (state_q)
                SCAN:     if (dwell_end && rs_any) state_d = PRESS_DB;
                PRESS_DB: begin
                    if (!rs_match)   state_d = SCAN;
                    else if (db_end) state_d = HELD;
                end
                HELD:     if (!rs_any && db_end) state_d = SCAN;
                default:  state_d = SCAN;
            endcase
        end
    end

    // Counter, column and key-event updates for the current state.
    always_comb begin
        col_idx_d = col_idx_q;
        dwell_d   = dwell_q;
        db_d      = db_q;
        pat_d     = pat_q;
        code_d    = code_q;
        ascii_d   = ascii_q;
        valid_d   = 1'b0;
        held_d    = held_q;
        if (!en_i) begin
            col_idx_d = 2'd0;
            dwell_d   = '0;
            db_d      = '0;
            held_d    = 1'b0;
        end else begin
            case (state_q)
                SCAN: begin
                    if (dwell_end) begin
                        dwell_d = '0;
                        if (rs_any) begin
                            pat_d = rs;
                            db_d  = '0;
                        end else begin
                            col_idx_d = col_idx_q + 2'd1;
                        end
                    end else begin
                        dwell_d = dwell_q + CNT_ONE;
                    end
                end
                PRESS_DB: begin
                    if (!rs_match) begin
                        col_idx_d = col_idx_q + 2'd1;
                        dwell_d   = '0;
                        db_d      = '0;
                    end else if (db_end) begin
                        code_d  = code_new;
                        ascii_d = KEY_ASCII[code_new];
                        valid_d = 1'b1;
                        held_d  = 1'b1;
                        db_d    = '0;
                    end else begin
                        db_d = db_q + CNT_ONE;
                    end
                end
                HELD: begin
                    if (rs_any) begin
                        db_d = '0;
                    end else if (db_end) begin
                        held_d    = 1'b0;
                        col_idx_d = col_idx_q + 2'd1;
                        dwell_d   = '0;
                        db_d      = '0;
                    end else begin
                        db_d = db_q + CNT_ONE;
                    end
                end
                default: begin
                    col_idx_d = 2'd0;
                    dwell_d   = '0;
                    db_d      = '0;
                    held_d    = 1'b0;
                end
            endcase
        end
        col_d = 4'b0001 << col_idx_d;
    end

    assign col_o       = col_q;
    assign key_valid_o = valid_q;
    assign key_code_o  = code_q;
    assign key_ascii_o = ascii_q;
    assign key_held_o  = held_q;

endmodule
